// File: rtl/div_unit_pkg.sv
// Shared types for the multi-cycle divider: FSM state encoding and default width.
// No logic, no latency, no flow control; imported by div_unit and its step datapath.
// Backpressure: not applicable.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } divState_t;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
// Latency: purely combinational, zero cycles.
// Backpressure: none, the owning FSM decides when to register the outputs.
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] quoIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic [WIDTH-1:0] quoOut
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Partial remainder stays below the divisor, so WIDTH+1 bits hold the sign of the trial.
  assign shifted = {remIn, quoIn[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  assign remOut = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quoOut = {quoIn[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// MIPS DIV/DIVU engine in E: radix-2 restoring divide; optional DIV_EARLY_OUT_EN skips trivial cases.
// Latency: 1 IDLE + WIDTH BUSY cycles (1 cycle on early-out), results held in DONE.
// Backpressure: stall_divE freezes the pipe until DONE; mem_stall holds DONE and its results.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             divE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             flushE,
  input  logic             mem_stall,
  output logic             stall_divE,
  output logic [WIDTH-1:0] div_hiE,
  output logic [WIDTH-1:0] div_loE,
  output logic             div_doneE
);

  localparam int CntW = $clog2(WIDTH);

  divState_t        state, stateNext;
  logic [CntW-1:0]  count;
  logic [WIDTH-1:0] remR, quoR, divisorR;
  logic [WIDTH-1:0] remStep, quoStep;
  logic [WIDTH-1:0] absA, absB;
  logic             quoNegR, remNegR, zeroDivR;
  logic             start, lastStep, earlyOut;

  assign absA = (signedE && srcaE[WIDTH-1]) ? -srcaE : srcaE;
  assign absB = (signedE && srcbE[WIDTH-1]) ? -srcbE : srcbE;

`ifdef DIV_EARLY_OUT_EN
  assign earlyOut = (absB == '0) || (absA < absB);
`else
  assign earlyOut = 1'b0;
`endif

  assign start    = (state == DIV_IDLE) && divE && !flushE;
  assign lastStep = (state == DIV_BUSY) && divE && !flushE && (count == CntW'(WIDTH - 1));

  div_unit_step #(.WIDTH(WIDTH)) uStep (
    .remIn   (remR),
    .quoIn   (quoR),
    .divisor (divisorR),
    .remOut  (remStep),
    .quoOut  (quoStep)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= DIV_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    if (flushE) begin
      stateNext = DIV_IDLE;
    end else begin
      unique case (state)
        DIV_IDLE: if (divE) stateNext = earlyOut ? DIV_DONE : DIV_BUSY;
        DIV_BUSY: begin
          if (!divE)         stateNext = DIV_IDLE;
          else if (lastStep) stateNext = DIV_DONE;
        end
        DIV_DONE: if (!mem_stall) stateNext = DIV_IDLE;
        default:  stateNext = DIV_IDLE;
      endcase
    end
  end

  // A flushed DONE must not reach the HI/LO write path.
  always_comb begin
    stall_divE = 1'b0;
    div_doneE  = 1'b0;
    if (resetn) begin
      stall_divE = divE && !flushE && (state != DIV_DONE);
      div_doneE  = (state == DIV_DONE) && !flushE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count    <= '0;
      remR     <= '0;
      quoR     <= '0;
      divisorR <= '0;
      quoNegR  <= 1'b0;
      remNegR  <= 1'b0;
      zeroDivR <= 1'b0;
      div_hiE  <= '0;
      div_loE  <= '0;
    end else if (start) begin
      count    <= '0;
      remR     <= '0;
      quoR     <= absA;
      divisorR <= absB;
      quoNegR  <= signedE && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
      remNegR  <= signedE && srcaE[WIDTH-1];
      zeroDivR <= (srcbE == '0);
      if (earlyOut) begin
        div_hiE <= srcaE;
        div_loE <= (srcbE == '0) ? '1 : '0;
      end
    end else if (state == DIV_BUSY) begin
      count <= count + CntW'(1);
      remR  <= remStep;
      quoR  <= quoStep;
      if (lastStep) begin
        // Divide-by-zero quotient is all ones regardless of operand signs.
        div_loE <= zeroDivR ? '1 : (quoNegR ? -quoStep : quoStep);
        div_hiE <= remNegR ? -remStep : remStep;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboarded bench for div_unit: expected HI/LO queued at issue, popped on div_doneE.
// Latency expectation follows DIV_EARLY_OUT_EN when defined.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn, divE, signedE, flushE, mem_stall;
  logic [31:0] srcaE, srcbE;
  logic        stall_divE, div_doneE;
  logic [31:0] div_hiE, div_loE;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .divE       (divE),
    .signedE    (signedE),
    .srcaE      (srcaE),
    .srcbE      (srcbE),
    .flushE     (flushE),
    .mem_stall  (mem_stall),
    .stall_divE (stall_divE),
    .div_hiE    (div_hiE),
    .div_loE    (div_loE),
    .div_doneE  (div_doneE)
  );

  function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic int latency(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub;
    int          lat;
    ua  = (sg && a[31]) ? -a : a;
    ub  = (sg && b[31]) ? -b : b;
    lat = 33;
`ifdef DIV_EARLY_OUT_EN
    if (ub == 32'd0 || ua < ub) lat = 1;
`else
    if (ua == 32'd1 && ub == 32'd1 && lat == 0) lat = 0;
`endif
    return lat;
  endfunction

  task automatic runDiv(input string name, input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit keepE);
    int          stallCnt;
    int          expStall;
    bit          seen;
    logic [63:0] exp;
    expStall = latency(sg, a, b);
    @(posedge clk); #1;
    flushE  = 1'b0;
    divE    = 1'b1;
    signedE = sg;
    srcaE   = a;
    srcbE   = b;
    sb.push_back(model(sg, a, b));
    stallCnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (div_doneE) seen = 1'b1;
      else if (stall_divE) stallCnt++;
    end
    exp = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: div_doneE not seen within 200 cycles", name);
      divE = 1'b0;
      return;
    end
    checks++;
    if (stallCnt !== expStall) begin
      errors++;
      $display("FAIL %s stall cycles: got %0d expected %0d", name, stallCnt, expStall);
    end
    checks++;
    if (div_hiE !== exp[63:32]) begin
      errors++;
      $display("FAIL %s HI: got %h expected %h", name, div_hiE, exp[63:32]);
    end
    checks++;
    if (div_loE !== exp[31:0]) begin
      errors++;
      $display("FAIL %s LO: got %h expected %h", name, div_loE, exp[31:0]);
    end
    checks++;
    if (stall_divE !== 1'b0) begin
      errors++;
      $display("FAIL %s stall in DONE: got %b expected 0", name, stall_divE);
    end
    if (hold > 0) begin
      mem_stall = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        checks++;
        if (div_doneE !== 1'b1 || stall_divE !== 1'b0 || {div_hiE, div_loE} !== exp) begin
          errors++;
          $display("FAIL %s hold: done=%b stall=%b hi=%h lo=%h expected done=1 stall=0 hi=%h lo=%h",
                   name, div_doneE, stall_divE, div_hiE, div_loE, exp[63:32], exp[31:0]);
        end
      end
      mem_stall = 1'b0;
    end
    if (!keepE) begin
      @(posedge clk); #1;
      divE = 1'b0;
      repeat (3) begin
        @(negedge clk);
        checks++;
        if (div_doneE !== 1'b0 || stall_divE !== 1'b0) begin
          errors++;
          $display("FAIL %s after release: done=%b stall=%b expected 0 0", name, div_doneE, stall_divE);
        end
      end
    end
  endtask

  task automatic test_reset;
    resetn    = 1'b0;
    divE      = 1'b1;
    signedE   = 1'b0;
    srcaE     = 32'd100;
    srcbE     = 32'd7;
    flushE    = 1'b0;
    mem_stall = 1'b0;
    #12;
    checks++;
    if (stall_divE !== 1'b0 || div_doneE !== 1'b0 || div_hiE !== 32'd0 || div_loE !== 32'd0) begin
      errors++;
      $display("FAIL reset: stall=%b done=%b hi=%h lo=%h expected 0 0 0 0",
               stall_divE, div_doneE, div_hiE, div_loE);
    end
    divE = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_basic;
    runDiv("divu_100_7", 1'b0, 32'd100, 32'd7, 0, 1'b0);
    runDiv("div_m7_2", 1'b1, -32'sd7, 32'd2, 0, 1'b0);
    runDiv("div_7_m2", 1'b1, 32'd7, -32'sd2, 0, 1'b0);
    runDiv("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    runDiv("divu_big", 1'b0, 32'hFFFF_FFF0, 32'd3, 0, 1'b0);
  endtask

  task automatic test_div_zero;
    runDiv("divu_5_0", 1'b0, 32'd5, 32'd0, 0, 1'b0);
    runDiv("div_m8_0", 1'b1, -32'sd8, 32'd0, 0, 1'b0);
  endtask

  task automatic test_early_out;
    runDiv("divu_3_10", 1'b0, 32'd3, 32'd10, 0, 1'b0);
    runDiv("div_m3_10", 1'b1, -32'sd3, 32'd10, 0, 1'b0);
  endtask

  task automatic test_mem_stall;
    runDiv("hold_1234_10", 1'b0, 32'd1234, 32'd10, 3, 1'b0);
  endtask

  task automatic test_back_to_back;
    runDiv("b2b_first", 1'b1, -32'sd1000, 32'd33, 0, 1'b1);
    runDiv("b2b_second", 1'b0, 32'd77, 32'd5, 0, 1'b0);
  endtask

  task automatic test_flush;
    @(posedge clk); #1;
    divE    = 1'b1;
    signedE = 1'b0;
    srcaE   = 32'd1000;
    srcbE   = 32'd7;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (stall_divE !== 1'b1) begin
      errors++;
      $display("FAIL flush busy stall: got %b expected 1", stall_divE);
    end
    flushE = 1'b1;
    #1;
    checks++;
    if (stall_divE !== 1'b0 || div_doneE !== 1'b0) begin
      errors++;
      $display("FAIL flush same cycle: stall=%b done=%b expected 0 0", stall_divE, div_doneE);
    end
    runDiv("divu_9_3_after_flush", 1'b0, 32'd9, 32'd3, 0, 1'b0);
  endtask

  task automatic test_async_reset;
    @(posedge clk); #1;
    divE    = 1'b1;
    signedE = 1'b1;
    srcaE   = -32'sd50;
    srcbE   = 32'd3;
    repeat (5) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (stall_divE !== 1'b0 || div_doneE !== 1'b0 || div_hiE !== 32'd0 || div_loE !== 32'd0) begin
      errors++;
      $display("FAIL async reset: stall=%b done=%b hi=%h lo=%h expected 0 0 0 0",
               stall_divE, div_doneE, div_hiE, div_loE);
    end
    divE = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    runDiv("div_m20_6_after_reset", 1'b1, -32'sd20, 32'd6, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_early_out();
    test_mem_stall();
    test_back_to_back();
    test_flush();
    test_async_reset();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
